// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux with registered grant, select and data.
// Optional tenure limit: define HOLD_LIMIT_EN to preempt holders after MAX_HOLD cycles.
module rr_mux_arbiter #(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [1:0]    ptr, ptr_n;
  logic [3:0]    gnt_n;
  logic [1:0]    sel_n;
  logic [DW-1:0] dout_n;
  logic          dout_valid_n;
  logic          busy_n;
  logic [DW-1:0] mux_data;
  logic [3:0]    others;
  logic [1:0]    win;
  logic          preempt;

  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_mux_arbiter: MAX_HOLD must be in 2..255");
    end
  endgenerate

  // First set bit of r, searching upward from p with wrap-around.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    mux_data = din0;
    case (sel)
      2'd0: mux_data = din0;
      2'd1: mux_data = din1;
      2'd2: mux_data = din2;
      2'd3: mux_data = din3;
    endcase
  end

  // While granted, gnt is one-hot on the holder, so this masks out the current holder.
  assign others = req & ~gnt;

`ifdef HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] cnt, cnt_n;
  assign preempt = req[sel] && (cnt == HOLD_LAST) && (|others);
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    gnt_n        = gnt;
    sel_n        = sel;
    dout_n       = dout;
    dout_valid_n = 1'b0;
    busy_n       = busy;
    win          = 2'd0;
`ifdef HOLD_LIMIT_EN
    cnt_n        = cnt;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          win     = rr_pick(req, ptr);
          gnt_n   = 4'b0001 << win;
          sel_n   = win;
          busy_n  = 1'b1;
          state_n = GRANT;
`ifdef HOLD_LIMIT_EN
          cnt_n   = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (req[sel]) begin
          dout_n       = mux_data;
          dout_valid_n = 1'b1;
        end
        // Release and preemption share one handover path; the old holder becomes lowest priority.
        if (!req[sel] || preempt) begin
          ptr_n = sel + 2'd1;
          if (|others) begin
            win   = rr_pick(others, sel + 2'd1);
            gnt_n = 4'b0001 << win;
            sel_n = win;
`ifdef HOLD_LIMIT_EN
            cnt_n = 8'd0;
`endif
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            sel_n   = 2'd0;
            busy_n  = 1'b0;
          end
        end else begin
`ifdef HOLD_LIMIT_EN
          if (cnt != HOLD_LAST) cnt_n = cnt + 8'd1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      gnt        <= 4'b0000;
      sel        <= 2'd0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
`ifdef HOLD_LIMIT_EN
      cnt        <= 8'd0;
`endif
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      gnt        <= gnt_n;
      sel        <= sel_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      busy       <= busy_n;
`ifdef HOLD_LIMIT_EN
      cnt        <= cnt_n;
`endif
    end
  end

endmodule
